alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Sequential front-end for the single-cycle 32-bit ALU: accepts operations over a valid/ready handshake, decodes the 2-bit ALU opcode and 6-bit function field into the 4-bit ALU control code, drives the ALU from registered operands and captures its result and zero flag into an output register. It sits between instruction decode and writeback, giving the ALU's control input its producing end. It adds backpressure-safe 2-stage buffering, illegal-operation flagging and operation counters.

## Interface
- CNT_W, 16, width of the accepted-operation and illegal-operation counters
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted on cycle where in_valid && in_ready
- alu_op  input  2  00 add, 01 subtract, 10 use funct, 11 reserved
- funct  input  6  function field, used only when alu_op=10
- in_a  input  32  first operand
- in_b  input  32  second operand
- alu_in1  output  32  to ALU first operand
- alu_in2  output  32  to ALU second operand
- alu_cont  output  4  to ALU control: 2 add, 6 sub, 0 and, 1 or, 3 xor
- alu_res  input  32  ALU result, combinational from alu_in1/alu_in2/alu_cont
- alu_zero  input  1  ALU zero flag
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes result on out_valid && out_ready
- result  output  32  captured ALU result
- zero  output  1  captured zero flag
- illegal  output  1  captured operation was undecodable
- ops_cnt  output  CNT_W  operations accepted since reset
- ill_cnt  output  CNT_W  illegal operations accepted since reset

## Operation
- Decode at acceptance: alu_op 00 -> 2; 01 -> 6; 10 with funct 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 100110 -> 3; any other funct, or alu_op 11 -> code 2 with illegal=1.
- Stage 1 (S1) registers: s1_valid, operands, decoded code, illegal bit; alu_in1/alu_in2/alu_cont are driven directly from S1 registers.
- Stage 2 (S2) registers: out_valid, result, zero, illegal, loaded from alu_res/alu_zero and S1 illegal bit.
- s2_free = !out_valid || out_ready; S1 advances into S2 when s1_valid && s2_free.
- in_ready = !s1_valid || s2_free (combinational; no dependence on in_valid).
- S1 loads on accept; clears s1_valid when it advances and no new accept occurs same cycle.
- out_valid clears on out_ready when S1 is empty; reloads same cycle when S1 advances.
- Illegal operations still traverse the pipe and produce an add result; illegal=1 marks them.
- ops_cnt +1 per accept; ill_cnt +1 per accepted illegal op; both wrap from 2^CNT_W-1 to 0.
- While stalled (out_valid && !out_ready), S1 and S2 contents and alu_in1/alu_in2/alu_cont hold stable.

## Timing
- Reset (rst=1 at a clk edge): s1_valid=0, out_valid=0, result=0, zero=0, illegal=0, alu_in1=0, alu_in2=0, alu_cont=2, ops_cnt=0, ill_cnt=0; in_ready=1 in the first cycle after reset.
- Reset mid-operation discards both stages; no result from before reset appears afterwards; an offer during a rst=1 cycle is not accepted and not counted.
- Latency: accept at edge N -> S1 valid after N -> out_valid after edge N+1 (result visible 2 edges after the accept edge).
- Throughput: one operation per cycle with out_ready held high.
- Full (both stages valid, out_ready=0): in_ready=0. With out_ready=1 in that state, S1 advances and a new op is accepted the same cycle (no bubble).
- Results emerge strictly in acceptance order; none dropped or duplicated.

## Test plan
- Reset then single add: alu_op=00, in_a=5, in_b=7, out_ready=1 -> two edges later out_valid=1, result=12, zero=0, illegal=0, ops_cnt=1.
- Funct decode sweep: alu_op=10, a=0xF0F0F0F0, b=0x0FF00FF0, funct sub/and/or/xor -> alu_cont 6/0/1/3 in S1; results 0xE100E100, 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00 in order.
- Zero and illegal: alu_op=01, a=b=0x1234 -> result=0, zero=1; alu_op=10 funct=000111, a=1, b=2 -> result=3, illegal=1, ill_cnt=1.
- Backpressure: stream 4 adds (i+i, i=1..4), out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, out_valid holds result=2 stable; release -> results 2,4,6,8 in order, no bubble at release.
- Reset mid-stream: both stages valid, assert rst one cycle -> out_valid=0, counters 0, alu_cont=2; no stale result appears afterward.
- Counter wrap (CNT_W=4): accept 17 ops -> ops_cnt=1.

Source files
------------

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Two-stage valid/ready issue front-end for a single-cycle 32-bit
//            ALU. Decodes opcode/funct into the ALU control code, drives the
//            ALU from stage-1 registers, and captures the result, zero flag
//            and an illegal-operation marker in stage 2. Also counts accepted
//            and illegal operations.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  output logic [31:0]      alu_in1_o,
  output logic [31:0]      alu_in2_o,
  output logic [3:0]       alu_cont_o,
  input  logic [31:0]      alu_res_i,
  input  logic             alu_zero_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      result_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] ops_cnt_o,
  output logic [CNT_W-1:0] ill_cnt_o
);

  localparam logic [3:0] c_CTL_AND = 4'd0;
  localparam logic [3:0] c_CTL_OR  = 4'd1;
  localparam logic [3:0] c_CTL_ADD = 4'd2;
  localparam logic [3:0] c_CTL_XOR = 4'd3;
  localparam logic [3:0] c_CTL_SUB = 4'd6;

  // Stage 1: operands and decoded control feeding the ALU
  logic        s1_valid_q;
  logic [31:0] s1_a_q;
  logic [31:0] s1_b_q;
  logic [3:0]  s1_cont_q;
  logic        s1_ill_q;

  // Stage 2: captured ALU outcome
  logic        s2_valid_q;
  logic [31:0] s2_res_q;
  logic        s2_zero_q;
  logic        s2_ill_q;

  logic [CNT_W-1:0] ops_cnt_q, ops_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic       w_s2_free;
  logic       w_advance;
  logic       w_accept;
  logic [3:0] w_dec_cont;
  logic       w_dec_ill;

  assign w_s2_free  = !s2_valid_q || out_ready_i;
  assign w_advance  = s1_valid_q && w_s2_free;
  assign in_ready_o = !s1_valid_q || w_s2_free;
  assign w_accept   = in_valid_i && in_ready_o;

  // Opcode/funct decode; undecodable operations fall back to add and are flagged
  always_comb begin
    w_dec_cont = c_CTL_ADD;
    w_dec_ill  = 1'b0;
    case (alu_op_i)
      2'b00: w_dec_cont = c_CTL_ADD;
      2'b01: w_dec_cont = c_CTL_SUB;
      2'b10: begin
        case (funct_i)
          6'b100000: w_dec_cont = c_CTL_ADD;
          6'b100010: w_dec_cont = c_CTL_SUB;
          6'b100100: w_dec_cont = c_CTL_AND;
          6'b100101: w_dec_cont = c_CTL_OR;
          6'b100110: w_dec_cont = c_CTL_XOR;
          default:   w_dec_ill  = 1'b1;
        endcase
      end
      default: w_dec_ill = 1'b1;
    endcase
  end

  // Stage 1 loads on accept; operands hold otherwise so the ALU inputs stay stable
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= 32'd0;
      s1_b_q     <= 32'd0;
      s1_cont_q  <= c_CTL_ADD;
      s1_ill_q   <= 1'b0;
    end else if (w_accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= in_a_i;
      s1_b_q     <= in_b_i;
      s1_cont_q  <= w_dec_cont;
      s1_ill_q   <= w_dec_ill;
    end else if (w_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 captures the ALU outcome when stage 1 advances, empties when consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= 32'd0;
      s2_zero_q  <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else if (w_advance) begin
      s2_valid_q <= 1'b1;
      s2_res_q   <= alu_res_i;
      s2_zero_q  <= alu_zero_i;
      s2_ill_q   <= s1_ill_q;
    end else if (out_ready_i) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Next-state for the wrapping operation counters
  always_comb begin
    ops_cnt_d = ops_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (w_accept) begin
      ops_cnt_d = ops_cnt_q + 1'b1;
      if (w_dec_ill) begin
        ill_cnt_d = ill_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      ops_cnt_q <= ops_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign alu_in1_o   = s1_a_q;
  assign alu_in2_o   = s1_b_q;
  assign alu_cont_o  = s1_cont_q;
  assign out_valid_o = s2_valid_q;
  assign result_o    = s2_res_q;
  assign zero_o      = s2_zero_q;
  assign illegal_o   = s2_ill_q;
  assign ops_cnt_o   = ops_cnt_q;
  assign ill_cnt_o   = ill_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_unit
// Brief    : Self-checking bench for alu_issue_unit: directed table vectors,
//            backpressure/reset/wrap sequences and randomized traffic against
//            a latency/queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [31:0]   in_a, in_b;
  logic [31:0]   alu_in1, alu_in2;
  logic [3:0]    alu_cont;
  logic [31:0]   alu_res;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   result;
  logic          zero;
  logic          illegal;
  logic [CW-1:0] ops_cnt, ill_cnt;

  alu_issue_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_op_i(alu_op), .funct_i(funct), .in_a_i(in_a), .in_b_i(in_b),
    .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_cont_o(alu_cont),
    .alu_res_i(alu_res), .alu_zero_i(alu_zero),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero), .illegal_o(illegal),
    .ops_cnt_o(ops_cnt), .ill_cnt_o(ill_cnt)
  );

  always #5 clk = ~clk;

  // The single-cycle ALU the unit drives
  always_comb begin
    alu_res = 32'd0;
    case (alu_cont)
      4'd2: alu_res = alu_in1 + alu_in2;
      4'd6: alu_res = alu_in1 - alu_in2;
      4'd0: alu_res = alu_in1 & alu_in2;
      4'd1: alu_res = alu_in1 | alu_in2;
      4'd3: alu_res = alu_in1 ^ alu_in2;
      default: alu_res = 32'd0;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: what an accepted operation must produce
  function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill);
    ill = 1'b0;
    r   = a + b;
    if (op == 2'b01) r = a - b;
    else if (op == 2'b11) ill = 1'b1;
    else if (op == 2'b10) begin
      case (f)
        6'h20:   r = a + b;
        6'h22:   r = a - b;
        6'h24:   r = a & b;
        6'h25:   r = a | b;
        6'h26:   r = a ^ b;
        default: ill = 1'b1;
      endcase
    end
  endfunction

  typedef struct {
    logic [31:0] res;
    logic        zr;
    logic        ill;
    int          acc_cyc;
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          ops_m = 0;
  int          ill_m = 0;
  bit          stall_prev = 0;
  bit          full_prev = 0;
  logic [31:0] sv_res, sv_in1, sv_in2;
  logic [3:0]  sv_cont;

  // One clock cycle: check state against model, record handshakes, advance
  task automatic tick(output bit acc);
    bit          cons;
    item_t       it;
    logic [31:0] r;
    logic        il;
    bit          exp_ov;
    #1;
    if (stall_prev) begin
      chk("stall_result", result, sv_res);
      if (full_prev) begin
        chk("stall_in1", alu_in1, sv_in1);
        chk("stall_in2", alu_in2, sv_in2);
        chk("stall_cont", {28'd0, alu_cont}, {28'd0, sv_cont});
      end
    end
    exp_ov = (q.size() > 0) && ((cyc - q[0].acc_cyc) >= 2);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
    chk("ops_cnt", {28'd0, ops_cnt}, ops_m & 15);
    chk("ill_cnt", {28'd0, ill_cnt}, ill_m & 15);
    acc  = in_valid && in_ready && !rst;
    cons = out_valid && out_ready && !rst;
    stall_prev = out_valid && !out_ready && !rst;
    full_prev  = stall_prev && (q.size() == 2);
    sv_res = result; sv_in1 = alu_in1; sv_in2 = alu_in2; sv_cont = alu_cont;
    if (cons) begin
      if (q.size() == 0) begin
        chk("spurious_result", 32'd1, 32'd0);
      end else begin
        it = q.pop_front();
        chk("result", result, it.res);
        chk("zero", {31'd0, zero}, {31'd0, it.zr});
        chk("illegal", {31'd0, illegal}, {31'd0, it.ill});
      end
    end
    if (acc) begin
      ref_op(alu_op, funct, in_a, in_b, r, il);
      it.res = r; it.zr = (r == 32'd0); it.ill = il; it.acc_cyc = cyc;
      q.push_back(it);
      ops_m++;
      if (il) ill_m++;
    end
    if (rst) begin
      q.delete();
      ops_m = 0;
      ill_m = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a, b, res;
    logic        zr, ill;
    logic [3:0]  cont;
  } vec_t;

  vec_t vt[9];

  initial begin
    bit acc;
    int idx;
    logic [5:0] legal_f[5];
    legal_f[0] = 6'h20; legal_f[1] = 6'h22; legal_f[2] = 6'h24;
    legal_f[3] = 6'h25; legal_f[4] = 6'h26;

    vt[0] = '{2'b00, 6'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 4'd2};
    vt[1] = '{2'b10, 6'h22, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hE100E100, 1'b0, 1'b0, 4'd6};
    vt[2] = '{2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 4'd0};
    vt[3] = '{2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 4'd1};
    vt[4] = '{2'b10, 6'h26, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 4'd3};
    vt[5] = '{2'b10, 6'h20, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00E100E0, 1'b0, 1'b0, 4'd2};
    vt[6] = '{2'b01, 6'h00, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 4'd6};
    vt[7] = '{2'b10, 6'h07, 32'd1,        32'd2,        32'd3,        1'b0, 1'b1, 4'd2};
    vt[8] = '{2'b11, 6'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 4'd2};

    rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0;
    in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
    tick(acc); tick(acc);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_cont", {28'd0, alu_cont}, 32'd2);

    // Table vectors: one op each, checked in S1 and at the output
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; alu_op = vt[i].op; funct = vt[i].f;
      in_a = vt[i].a; in_b = vt[i].b;
      tick(acc);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_cont", i), {28'd0, alu_cont}, {28'd0, vt[i].cont});
      tick(acc);
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_res", i), result, vt[i].res);
      chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vt[i].zr});
      chk($sformatf("vec%0d_ill", i), {31'd0, illegal}, {31'd0, vt[i].ill});
      if (i == 0) chk("single_add_ops", {28'd0, ops_cnt}, 32'd1);
      if (i == 7) chk("first_ill_cnt", {28'd0, ill_cnt}, 32'd1);
      tick(acc);
    end

    // Backpressure: stream i+i, consumer stalled for 5 cycles
    out_ready = 1'b0; alu_op = 2'b00; idx = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) out_ready = 1'b1;
      in_valid = (idx <= 4);
      in_a = idx; in_b = idx;
      if (c == 3) begin
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_result", result, 32'd2);
      end
      tick(acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 5);
    in_valid = 1'b0;

    // Reset with both stages full and an offer during the reset cycle
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'd100; in_b = 32'd1;
    tick(acc); tick(acc); tick(acc);
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_ops_cnt", {28'd0, ops_cnt}, 32'd0);
    chk("mid_ill_cnt", {28'd0, ill_cnt}, 32'd0);
    chk("mid_cont", {28'd0, alu_cont}, 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick(acc);

    // Counter wrap: 17 accepts on a 4-bit counter
    in_valid = 1'b1; alu_op = 2'b00; idx = 0;
    for (int c = 0; c < 40 && idx < 17; c++) begin
      in_a = idx; in_b = 32'd3;
      tick(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("wrap_ops_cnt", {28'd0, ops_cnt}, 32'd1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      alu_op    = 2'($urandom_range(0, 3));
      funct     = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63))
                                              : legal_f[$urandom_range(0, 4)];
      in_a      = ($urandom_range(0, 4) == 0) ? in_b : $urandom;
      in_b      = $urandom;
      tick(acc);
    end

    // Drain with a bounded budget
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) tick(acc);
    chk("drain_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
